mac_dot_seq: RTL
================

Name: mac_dot_seq

Overview:
- Upstream sequencer and result-capture stage wrapped around the 8x8→20-bit MAC.
- Accepts a stream of LEN operand pairs over a valid/ready handshake and drives the MAC operand and clear inputs.
- Waits out the MAC's 2-stage pipeline, then captures the finished dot product and presents it on a valid/ready output.
- This is the only block that drives the MAC's sclr, i_a and i_b.

Parameters:
- LEN, 16, pairs per dot product; legal range 1..16 (16×255×255 = 1,040,400 fits 20 bits); elaboration error outside range.
- CW, $clog2(LEN+1), element counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a dot product; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in RUN.
- in_a  in  8  unsigned operand A.
- in_b  in  8  unsigned operand B.
- mac_a  out  8  to MAC i_a.
- mac_b  out  8  to MAC i_b.
- mac_sclr  out  1  to MAC sclr.
- mac_result  in  20  from MAC o_mac.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_data  out  20  captured dot product.

Behaviour:
- MAC timing: operands registered into the product at edge t; the product is added to psum at edge t+1; sclr=1 zeroes both at the edge.
- States: IDLE, RUN, DRAIN1, DRAIN2, DONE.
- Reset: state=IDLE, count=0, out_valid=0, out_data=0.
  - Therefore busy=0, in_ready=0, mac_sclr=1, mac_a=mac_b=0.
- mac_sclr=1 in IDLE and DONE, 0 otherwise, so the MAC is held clear while unused.
- mac_a/mac_b = in_a/in_b when (in_valid && in_ready), else 0.
  - Bubbles inject zero products, never stale data.
- IDLE: start=1 → RUN, count←0. The sclr edge in this cycle guarantees psum=0 on RUN entry.
- RUN: accept when in_valid && in_ready, count←count+1.
  - On the accept making count==LEN → DRAIN1.
  - in_valid=0 holds RUN indefinitely; no timeout.
- DRAIN1 → DRAIN2 unconditionally. Last product is folded into psum at the end of DRAIN1.
- DRAIN2 → DONE: out_data←mac_result, out_valid←1.
- DONE: hold out_data/out_valid stable until out_ready=1.
  - On handshake: out_valid←0, → IDLE.
- Latency: out_valid rises 2 cycles after the edge accepting the last pair.
- Minimum start-to-out_valid: LEN+3 cycles with no bubbles.
- start while busy: ignored; no queuing.
- start in the DONE handshake cycle: ignored; must be reasserted in IDLE.
- out_ready while out_valid=0: no effect.
- rst mid-operation (any state): immediate return to reset values; partial sum discarded.
  - MAC is cleared by mac_sclr=1 at the next edge.
- Arithmetic: all unsigned. The block does no summation; out_data is a 20-bit copy of mac_result, with no saturation needed given the LEN bound.

Decomposition:
- Shared package holds:
  - state enum typedef (IDLE/RUN/DRAIN1/DRAIN2/DONE);
  - localparams OPW=8, ACCW=20, MAC_LAT=2, LEN_MAX=16.
- No sub-module: a single FSM plus counter and output register.
- Top-level integration instantiates mac_dot_seq beside mac.

Test Plan:
- LEN=4, pairs (1,2),(3,4),(5,6),(7,8), no bubbles → out_data=100, out_valid exactly 2 cycles after the 4th accept.
- LEN=16, all pairs (255,255) → out_data=1,040,400; no overflow.
- LEN=4, same pairs with in_valid low 3 cycles between pairs 2 and 3 → out_data=100; mac_a/mac_b=0 during bubbles.
- out_ready held low 5 cycles after out_valid → out_data stable at 100, busy=1, start pulses ignored; after handshake, new run with pairs (2,2)×4 → 16.
- rst asserted during RUN after 2 accepts → next cycle IDLE, mac_sclr=1, out_valid=0; fresh run with (1,1)×4 → 4.
- start asserted in DRAIN1/DONE → no effect on result or state sequence; back-to-back runs give independent correct sums.

Source files
------------

// File: rtl/mac_dot_seq_pkg.sv
// Shared types and sizing constants for the MAC dot-product sequencer.
package mac_dot_seq_pkg;

  // Operand width, MAC accumulator width, MAC pipeline depth and the
  // largest dot-product length that cannot overflow the accumulator.
  localparam int OPW     = 8;
  localparam int ACCW    = 20;
  localparam int MAC_LAT = 2;
  localparam int LEN_MAX = 16;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage : mac_dot_seq_pkg

// File: rtl/mac_dot_seq.sv
// Sequencer and result-capture stage around the 8x8->20-bit MAC.
// It streams LEN operand pairs into the MAC, waits out the MAC pipeline
// and presents the finished dot product on a valid/ready output.
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  output logic [OPW-1:0]  mac_a,
  output logic [OPW-1:0]  mac_b,
  output logic            mac_sclr,
  input  logic [ACCW-1:0] mac_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_data
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

  // Lengths above LEN_MAX could overflow the 20-bit accumulator.
  generate
    if ((LEN < 1) || (LEN > LEN_MAX)) begin : g_len_check
      $error("mac_dot_seq: LEN must be in 1..16");
    end
  endgenerate

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic            r_out_valid;
  logic [ACCW-1:0] r_out_data;
  logic            w_accept;

  // Next-state decode plus the combinational handshake and MAC drive.
  // NOTE: every output of this block gets a default first so that no path
  // through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    in_ready = 1'b0;
    mac_sclr = 1'b0;
    w_accept = 1'b0;
    mac_a    = '0;
    mac_b    = '0;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        mac_sclr = 1'b1;
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Only accepted pairs reach the MAC; bubbles feed zero products.
          w_accept = 1'b1;
          mac_a    = in_a;
          mac_b    = in_b;
          if (r_count == LAST_IDX) w_next = S_DRAIN1;
        end
      end
      // Last product is registered; it reaches psum at the end of DRAIN1.
      S_DRAIN1: w_next = S_DRAIN2;
      // mac_result now holds the complete sum; capture happens at this edge.
      S_DRAIN2: w_next = S_DONE;
      S_DONE: begin
        mac_sclr = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Element counter: cleared on start, advanced on each accepted pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Result register: capture the finished sum, hold it until handshake.
  // NOTE: out_data is reset too, so the output is defined before the first
  // run completes; the register is tiny, so there is no reason to skip it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_state == S_DRAIN2) begin
      r_out_valid <= 1'b1;
      r_out_data  <= mac_result;
    end else if ((r_state == S_DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule : mac_dot_seq
